// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared anode patterns, slot index and scanner state types
package display_pkg;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [3:0] DIGIT0    = 4'b1110;
  localparam logic [3:0] DIGIT1    = 4'b1101;
  localparam logic [3:0] DIGIT2    = 4'b1011;
  localparam logic [3:0] DIGIT3    = 4'b0111;

  typedef logic [1:0] slot_t;

  typedef enum logic {BLANK, SHOW} scan_state_t;

  function automatic logic [3:0] slot_anode(input slot_t slot);
    case (slot)
      2'd0:    slot_anode = DIGIT0;
      2'd1:    slot_anode = DIGIT1;
      2'd2:    slot_anode = DIGIT2;
      default: slot_anode = DIGIT3;
    endcase
  endfunction

endpackage

// File: rtl/slot_counter.sv
// rtl/slot_counter.sv - loadable down-counter, done on the last cycle of a state
module slot_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - four-digit display scanner with per-frame operand capture
// Optional inter-digit blanking is compiled in with `define SCAN_BLANK_EN.
module display_scanner #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       freeze,
  output logic [3:0] anode,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic [3:0] sum_out,
  output logic [3:0] diff_out,
  output logic       frame_start
);

  import display_pkg::*;

  localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SHOW_LOAD = CW'(TICK_DIV - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
`endif

  scan_state_t     state_q, state_d;
  slot_t           slot_q, slot_d;
  logic            running_q;
  logic            load;
  logic [CW-1:0]   load_val;
  logic            done;
  logic            boundary;
  logic [3:0]      anode_d;

  slot_counter #(.WIDTH(CW)) u_slot_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_val),
    .done       (done)
  );

  // The first edge out of reset behaves as a frame boundary into slot 0.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    load     = 1'b0;
    load_val = SHOW_LOAD;
    boundary = 1'b0;
    anode_d  = anode;
    if (!running_q) begin
      boundary = 1'b1;
      slot_d   = 2'd0;
      load     = 1'b1;
`ifdef SCAN_BLANK_EN
      state_d  = BLANK;
      load_val = BLANK_LOAD;
      anode_d  = ANODE_OFF;
`else
      state_d  = SHOW;
      anode_d  = slot_anode(2'd0);
`endif
    end
`ifdef SCAN_BLANK_EN
    else if (done && state_q == BLANK) begin
      load    = 1'b1;
      state_d = SHOW;
      anode_d = slot_anode(slot_q);
    end
`endif
    else if (done && state_q == SHOW) begin
      load     = 1'b1;
      slot_d   = slot_t'(slot_q + 2'd1);
      boundary = (slot_q == 2'd3);
`ifdef SCAN_BLANK_EN
      state_d  = BLANK;
      load_val = BLANK_LOAD;
      anode_d  = ANODE_OFF;
`else
      state_d  = SHOW;
      anode_d  = slot_anode(slot_t'(slot_q + 2'd1));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q   <= 1'b0;
      state_q     <= SHOW;
      slot_q      <= 2'd0;
      anode       <= ANODE_OFF;
      frame_start <= 1'b0;
      a_out       <= 4'd0;
      b_out       <= 4'd0;
      sum_out     <= 4'd0;
      diff_out    <= 4'd0;
    end else begin
      running_q   <= 1'b1;
      state_q     <= state_d;
      slot_q      <= slot_d;
      anode       <= anode_d;
      frame_start <= boundary;
      if (boundary && !freeze) begin
        a_out    <= in_a;
        b_out    <= in_b;
        sum_out  <= in_a + in_b;
        diff_out <= in_a - in_b;
      end
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - directed self-checking bench for display_scanner
module tb_display_scanner;

  localparam int TICK = 4;
`ifdef SCAN_BLANK_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif
  localparam int SL = TICK + BLK;
  localparam int P  = 4 * SL;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_a, in_b;
  logic       freeze;
  logic [3:0] anode, a_out, b_out, sum_out, diff_out;
  logic       frame_start;

  int checks = 0;
  int fails  = 0;

  display_scanner #(.TICK_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_a        (in_a),
    .in_b        (in_b),
    .freeze      (freeze),
    .anode       (anode),
    .a_out       (a_out),
    .b_out       (b_out),
    .sum_out     (sum_out),
    .diff_out    (diff_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_anode(input int k);
    int slot, pos;
    slot = k / SL;
    pos  = k % SL;
    if (pos < BLK) return 4'b1111;
    case (slot)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic chk_reset();
    chk("rst_anode", anode, 4'b1111);
    chk("rst_a", a_out, 4'd0);
    chk("rst_b", b_out, 4'd0);
    chk("rst_sum", sum_out, 4'd0);
    chk("rst_diff", diff_out, 4'd0);
    chk("rst_frame_start", {3'b0, frame_start}, 4'd0);
  endtask

  // Called at the negedge of frame cycle 0; checks nk cycles and applies one input change.
  task automatic run_frame(input logic [3:0] ea, eb, es, ed, input int nk,
                           input int chg_k, input logic [3:0] na, nb, input logic nf);
    for (int k = 0; k < nk; k++) begin
      chk("anode", anode, exp_anode(k));
      chk("frame_start", {3'b0, frame_start}, {3'b0, (k == 0)});
      chk("a_out", a_out, ea);
      chk("b_out", b_out, eb);
      chk("sum_out", sum_out, es);
      chk("diff_out", diff_out, ed);
      chk("anode_onehot", {3'b0, ($countones(~anode) <= 1)}, 4'd1);
      if (k == chg_k) begin
        in_a   = na;
        in_b   = nb;
        freeze = nf;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst    = 1'b1;
    in_a   = 4'd3;
    in_b   = 4'd5;
    freeze = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    run_frame(4'd3, 4'd5, 4'd8, 4'd14, P, SL + 1, 4'd7, 4'd5, 1'b0);
    run_frame(4'd7, 4'd5, 4'd12, 4'd2, P, 3, 4'd9, 4'd9, 1'b0);
    run_frame(4'd9, 4'd9, 4'd2, 4'd0, P, 5, 4'd0, 4'd1, 1'b0);
    run_frame(4'd0, 4'd1, 4'd1, 4'd15, P, 2, 4'd4, 4'd4, 1'b1);
    run_frame(4'd0, 4'd1, 4'd1, 4'd15, P, 6, 4'd4, 4'd4, 1'b0);
    run_frame(4'd4, 4'd4, 4'd8, 4'd0, 2 * SL + BLK + 2, -1, 4'd0, 4'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst  = 1'b0;
    in_a = 4'd2;
    in_b = 4'd6;
    @(negedge clk);
    run_frame(4'd2, 4'd6, 4'd8, 4'd12, P, -1, 4'd0, 4'd0, 1'b0);
    run_frame(4'd2, 4'd6, 4'd8, 4'd12, P, -1, 4'd0, 4'd0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexing front end for the four-digit seven-segment display. Captures the A/B operands once per display frame, computes the 4-bit sum and difference, and rotates the active-low anode select through the four digits at a fixed refresh rate. Its outputs drive the seven-segment decoder's `A`, `B`, `AplusB`, `AminusB` and `anode` inputs directly. Captured values only change at frame boundaries, so a frame never mixes old and new values.

## Interface
- `TICK_DIV`, 100000: clock cycles each digit is lit (1 kHz per digit at 100 MHz); must be ≥2.
- `BLANK_CYCLES`, 1000: all-off cycles before each digit when blanking is compiled in; must be ≥1.

- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_a`  in  4  live operand A.
- `in_b`  in  4  live operand B.
- `freeze`  in  1  when high at a frame boundary, the captured values are kept unchanged.
- `anode`  out  4  active-low digit select; registered.
- `a_out`  out  4  captured A.
- `b_out`  out  4  captured B.
- `sum_out`  out  4  captured (A+B) mod 16.
- `diff_out`  out  4  captured (A−B) mod 16.
- `frame_start`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Digit slot order: 0→1→2→3→0.
- Anode per slot, when lit:
  - slot 0: `1110` (A)
  - slot 1: `1101` (B)
  - slot 2: `1011` (A+B)
  - slot 3: `0111` (A−B)
- Blanked/off anode is `1111`.
- FSM states:
  - BLANK: anode `1111`; lasts BLANK_CYCLES cycles, then goes to SHOW with the same slot.
  - SHOW: anode shows the slot pattern; lasts TICK_DIV cycles. Then the slot advances modulo 4, and the next state is BLANK (with blanking) or SHOW (without).
- Without blanking, only the SHOW state is used.
- A frame boundary is the edge that enters slot 0, including the first edge after reset is released.
- At a frame boundary:
  - If `freeze` is low, capture `in_a` and `in_b`. Compute sum and difference as 4-bit modulo-16 arithmetic; carry and borrow are discarded.
  - Always pulse `frame_start`, even when `freeze` is high.
- Captured outputs never change except at a frame boundary.
- `in_a`/`in_b` changes between boundaries have no effect on the outputs.
- Reset values while `rst` is high: `anode=1111`, all data outputs 0, `frame_start=0`, slot 0, slot counter 0.
- `rst` asserted mid-slot or mid-frame:
  - Next edge forces the reset values.
  - Nothing partial is kept: no partially advanced slot and no stale capture.

## Timing
- First rising edge with `rst` low:
  - Frame boundary: capture happens and `frame_start=1` for that cycle.
  - `anode` becomes `1110` without blanking, or `1111` (BLANK of slot 0) with blanking.
- Without blanking:
  - Each anode pattern is held exactly TICK_DIV cycles.
  - Frame period is 4·TICK_DIV cycles.
- With blanking:
  - Each slot is BLANK_CYCLES cycles of `1111` followed by TICK_DIV cycles lit.
  - Frame period is 4·(TICK_DIV+BLANK_CYCLES) cycles.
- Capture latency: values on `in_a`/`in_b` at the boundary edge appear on the outputs in the following cycle, together with `frame_start`.
- `frame_start` is high for exactly one cycle per frame.
- At most one anode bit is low in any cycle.

## Configuration
- `SCAN_BLANK_EN` defined:
  - BLANK state compiled in; each digit is preceded by BLANK_CYCLES of all-off, which prevents segment ghosting.
- `SCAN_BLANK_EN` not defined:
  - BLANK state and `BLANK_CYCLES` logic are removed.
  - Each slot goes directly from one lit digit to the next lit digit.

## Structure
- Shared package `display_pkg` contains:
  - anode pattern constants: `ANODE_OFF=1111` and DIGIT0..3.
  - 2-bit slot index typedef.
  - scanner state enum {BLANK, SHOW}.
- Sub-module `slot_counter`:
  - Loadable down-counter sized for max(TICK_DIV, BLANK_CYCLES).
  - Asserts `done` on its last cycle; reloaded by the FSM on each state entry.

## Test plan
Benches use TICK_DIV=4 and BLANK_CYCLES=2.
- No blanking, reset released, `in_a=3`, `in_b=5` → first edge: `frame_start=1`, `a_out=3`, `b_out=5`, `sum_out=8`, `diff_out=14`. Anode sequence `1110`,`1101`,`1011`,`0111`, each held 4 cycles; period 16 cycles.
- `in_a=9`, `in_b=9` → `sum_out=2`, `diff_out=0`. `in_a=0`, `in_b=1` → `diff_out=15`.
- Change `in_a` from 3 to 7 during slot 1 → `a_out` stays 3 until the next `frame_start`, then becomes 7.
- `freeze=1` across a boundary → `frame_start` still pulses and all captured outputs are unchanged. Deassert `freeze` → next boundary captures.
- `SCAN_BLANK_EN` defined → each slot is 2 cycles of `1111` then 4 cycles lit; period 24 cycles; never more than one anode bit low.
- Assert `rst` for 1 cycle in the middle of slot 2 → next edge: `anode=1111`, outputs 0. After release, the sequence restarts at slot 0 with a `frame_start` pulse.
